// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Holds the FSM state encoding and the fairness streak default.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    localparam int MAX_DSTREAK_DEF = 4;

    // Counter width able to hold the value max itself
    function automatic int streak_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/mem_arb_streak.sv
// Counts data grants issued while a fetch is waiting.
// Raises force_fetch once the streak reaches MAX_DSTREAK.
module mem_arb_streak
    import mem_arb_pkg::*;
#(
    parameter int MAX_DSTREAK = MAX_DSTREAK_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_gnt,
    input  logic d_gnt,
    output logic force_fetch
);

    localparam int CW = streak_w(MAX_DSTREAK);

    logic [CW-1:0] cnt;

    // Streak restarts whenever fetch is idle or gets served
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!i_req || i_gnt) begin
            cnt <= '0;
        end else if (d_gnt && (cnt != CW'(MAX_DSTREAK))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign force_fetch = (cnt == CW'(MAX_DSTREAK));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch and load/store requesters.
// Define MEM_ARB_FAIR_EN to bound the data streak while fetch waits.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_DSTREAK = MAX_DSTREAK_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_flush,
    output logic          i_gnt,
    output logic          i_valid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic [3:0]    d_we,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_valid,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic [AW-1:0] m_addr,
    output logic [3:0]    m_we,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ready,
    input  logic [DW-1:0] m_rdata
);

    state_t state;
    state_t state_nxt;

    logic arb;
    logic grant_i;
    logic grant_d;
    logic fetch_first;
    logic flushed;
    logic done_i;
    logic done_d;

`ifdef MEM_ARB_FAIR_EN
    mem_arb_streak #(
        .MAX_DSTREAK(MAX_DSTREAK)
    ) u_streak (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_gnt      (grant_i),
        .d_gnt      (grant_d),
        .force_fetch(fetch_first)
    );
`else
    assign fetch_first = 1'b0;
`endif

    // Arbitration window and winner selection
    always_comb begin
        arb     = 1'b0;
        grant_d = 1'b0;
        grant_i = 1'b0;
        unique case (state)
            IDLE:    arb = 1'b1;
            IBUSY,
            DBUSY:   arb = m_ready;
            default: arb = 1'b0;
        endcase
        grant_d = arb && d_req && !(fetch_first && i_req);
        grant_i = arb && i_req && !grant_d;
    end

    // Next-state: a completed or idle slot goes to the winner
    always_comb begin
        state_nxt = state;
        if (arb) begin
            unique case (1'b1)
                grant_d: state_nxt = DBUSY;
                grant_i: state_nxt = IBUSY;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign i_gnt  = grant_i;
    assign d_gnt  = grant_d;
    assign m_req  = (state == IBUSY) || (state == DBUSY);
    assign done_i = (state == IBUSY) && m_ready;
    assign done_d = (state == DBUSY) && m_ready;

    // Capture the granted request onto the memory side
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_addr  <= '0;
            m_we    <= '0;
            m_wdata <= '0;
        end else if (grant_d) begin
            m_addr  <= d_addr;
            m_we    <= d_we;
            m_wdata <= d_wdata;
        end else if (grant_i) begin
            m_addr  <= i_addr;
            m_we    <= '0;
            m_wdata <= '0;
        end
    end

    // Remember a taken-branch flush for the fetch in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flushed <= 1'b0;
        end else if (done_i) begin
            flushed <= 1'b0;
        end else if ((state == IBUSY) && i_flush) begin
            flushed <= 1'b1;
        end
    end

    // Data response; stores acknowledge with zero data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_valid <= 1'b0;
            d_rdata <= '0;
        end else begin
            d_valid <= done_d;
            if (done_d) begin
                d_rdata <= (m_we != 4'd0) ? '0 : m_rdata;
            end
        end
    end

    // Fetch response, dropped if flushed now or earlier
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_valid <= 1'b0;
            i_rdata <= '0;
        end else begin
            i_valid <= done_i && !flushed && !i_flush;
            if (done_i && !flushed && !i_flush) begin
                i_rdata <= m_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference.
// Fairness expectations follow MEM_ARB_FAIR_EN when it is defined.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_flush = 1'b0;
    logic          i_gnt;
    logic          i_valid;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [3:0]    d_we = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt;
    logic          d_valid;
    logic [DW-1:0] d_rdata;
    logic          m_req;
    logic [AW-1:0] m_addr;
    logic [3:0]    m_we;
    logic [DW-1:0] m_wdata;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_rdata = '0;

    int errs = 0;
    int checks = 0;

    mem_arbiter #(
        .AW(AW),
        .DW(DW),
        .MAX_DSTREAK(MAXS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_req  (i_req),
        .i_addr (i_addr),
        .i_flush(i_flush),
        .i_gnt  (i_gnt),
        .i_valid(i_valid),
        .i_rdata(i_rdata),
        .d_req  (d_req),
        .d_addr (d_addr),
        .d_we   (d_we),
        .d_wdata(d_wdata),
        .d_gnt  (d_gnt),
        .d_valid(d_valid),
        .d_rdata(d_rdata),
        .m_req  (m_req),
        .m_addr (m_addr),
        .m_we   (m_we),
        .m_wdata(m_wdata),
        .m_ready(m_ready),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: one outstanding transaction plus pending responses
    int          cur;      // 0 none, 1 fetch, 2 data
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_we;
    bit          c_fl;
    int          streak;
    bit          e_iv;
    bit          e_dv;
    logic [31:0] e_ir;
    logic [31:0] e_dr;
    bit          m_arb;
    bit          m_wd;
    bit          m_wi;

    always @(negedge clk) begin
        if (!rst) begin
            cur = 0;
            c_fl = 0;
            streak = 0;
            e_iv = 0;
            e_dv = 0;
            check("rst_m_req", m_req, 0);
            check("rst_i_valid", i_valid, 0);
            check("rst_d_valid", d_valid, 0);
        end else begin
            m_arb = (cur == 0) || m_ready;
`ifdef MEM_ARB_FAIR_EN
            m_wd = m_arb && d_req && !(i_req && streak >= MAXS);
`else
            m_wd = m_arb && d_req;
`endif
            m_wi = m_arb && i_req && !m_wd;
            check("d_gnt", d_gnt, m_wd);
            check("i_gnt", i_gnt, m_wi);
            check("m_req", m_req, cur != 0);
            if (cur != 0) begin
                check("m_addr", m_addr, c_addr);
                check("m_we", m_we, c_we);
                check("m_wdata", m_wdata, c_wdata);
            end
            check("i_valid", i_valid, e_iv);
            check("d_valid", d_valid, e_dv);
            if (e_iv) check("i_rdata", i_rdata, e_ir);
            if (e_dv) check("d_rdata", d_rdata, e_dr);
            e_dv = (cur == 2) && m_ready;
            if (e_dv) e_dr = (c_we != 0) ? 32'h0 : m_rdata;
            e_iv = (cur == 1) && m_ready && !c_fl && !i_flush;
            if (e_iv) e_ir = m_rdata;
            if (cur == 1 && i_flush) c_fl = 1;
            if (!i_req || m_wi) streak = 0;
            else if (m_wd) streak++;
            if (m_arb) begin
                if (m_wd) begin
                    cur = 2;
                    c_addr = d_addr;
                    c_we = d_we;
                    c_wdata = d_wdata;
                end else if (m_wi) begin
                    cur = 1;
                    c_addr = i_addr;
                    c_we = 0;
                    c_wdata = 0;
                end else begin
                    cur = 0;
                end
                c_fl = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout expired");
        $fatal(1);
    end

    logic [7:0] exp_pat [10];
    logic [7:0] got;
    int nv;

    initial begin
`ifdef MEM_ARB_FAIR_EN
        exp_pat = '{"D", "D", "D", "D", "I", "D", "D", "D", "D", "I"};
`else
        exp_pat = '{"D", "D", "D", "D", "D", "D", "D", "D", "D", "D"};
`endif
        repeat (3) tick();
        rst = 1'b1;
        samp();
        check("reset_m_addr", m_addr, 0);
        check("reset_m_we", m_we, 0);
        check("reset_m_wdata", m_wdata, 0);
        check("reset_i_rdata", i_rdata, 0);
        check("reset_d_rdata", d_rdata, 0);

        // single load
        tick();
        d_req = 1; d_addr = 32'h100; d_we = 0;
        samp();
        check("load_gnt", d_gnt, 1);
        tick();
        d_req = 0; m_ready = 1; m_rdata = 32'hDEADBEEF;
        samp();
        check("load_m_req", m_req, 1);
        check("load_m_addr", m_addr, 32'h100);
        tick();
        m_ready = 0;
        samp();
        check("load_valid", d_valid, 1);
        check("load_rdata", d_rdata, 32'hDEADBEEF);

        // collision: store beats fetch, fetch follows with no gap
        tick();
        i_req = 1; i_addr = 32'h40;
        d_req = 1; d_addr = 32'h200; d_we = 4'hF; d_wdata = 32'h12345678;
        samp();
        check("coll_d_gnt", d_gnt, 1);
        check("coll_i_gnt0", i_gnt, 0);
        tick();
        d_req = 0; d_we = 0;
        samp();
        check("coll_m_we", m_we, 4'hF);
        check("coll_m_wdata", m_wdata, 32'h12345678);
        check("coll_i_wait", i_gnt, 0);
        tick();
        m_ready = 1; m_rdata = 32'h0;
        samp();
        check("coll_i_gnt", i_gnt, 1);
        tick();
        i_req = 0; m_rdata = 32'hCAFE0001;
        samp();
        check("coll_fetch_req", m_req, 1);
        check("coll_fetch_addr", m_addr, 32'h40);
        check("coll_fetch_we", m_we, 0);
        check("coll_store_ack", d_valid, 1);
        check("coll_store_rdata", d_rdata, 0);
        tick();
        m_ready = 0;
        samp();
        check("coll_i_valid", i_valid, 1);
        check("coll_i_rdata", i_rdata, 32'hCAFE0001);
        check("coll_idle", m_req, 0);

        // flush one cycle after grant
        tick();
        i_req = 1; i_addr = 32'h80;
        samp();
        check("flush_gnt", i_gnt, 1);
        tick();
        i_req = 0; i_flush = 1;
        samp();
        tick();
        i_flush = 0; m_ready = 1; m_rdata = 32'hBAD0BAD0;
        samp();
        tick();
        m_ready = 0;
        samp();
        check("flush_no_valid", i_valid, 0);
        check("flush_idle", m_req, 0);

        // flush coincident with completion
        tick();
        i_req = 1; i_addr = 32'h84;
        samp();
        check("flush2_gnt", i_gnt, 1);
        tick();
        i_req = 0; i_flush = 1; m_ready = 1; m_rdata = 32'hBAD1BAD1;
        samp();
        tick();
        i_flush = 0; m_ready = 0;
        samp();
        check("flush2_no_valid", i_valid, 0);

        // flush in idle is ignored; flag does not linger
        tick();
        i_flush = 1;
        tick();
        i_flush = 0; i_req = 1; i_addr = 32'h88;
        samp();
        check("fetch3_gnt", i_gnt, 1);
        tick();
        i_req = 0; m_ready = 1; m_rdata = 32'h11112222;
        tick();
        m_ready = 0;
        samp();
        check("fetch3_valid", i_valid, 1);
        check("fetch3_rdata", i_rdata, 32'h11112222);

        // wait states
        tick();
        d_req = 1; d_addr = 32'h300; d_we = 0;
        tick();
        d_req = 0; m_ready = 0; nv = 0;
        for (int i = 0; i < 5; i++) begin
            samp();
            check($sformatf("wait_addr%0d", i), m_addr, 32'h300);
            check($sformatf("wait_req%0d", i), m_req, 1);
            if (d_valid) nv++;
            tick();
        end
        m_ready = 1; m_rdata = 32'h5A5A5A5A;
        samp();
        if (d_valid) nv++;
        tick();
        m_ready = 0;
        samp();
        check("wait_rdata", d_rdata, 32'h5A5A5A5A);
        for (int i = 0; i < 3; i++) begin
            if (d_valid) nv++;
            tick();
            samp();
        end
        check("wait_one_valid", nv, 1);

        // asynchronous reset mid-access
        tick();
        d_req = 1; d_addr = 32'h400;
        tick();
        d_req = 0; m_ready = 0;
        samp();
        check("rst_busy", m_req, 1);
        @(posedge clk);
        #3;
        rst = 0;
        m_ready = 1; m_rdata = 32'h77777777;
        #1;
        check("rst_async_m_req", m_req, 0);
        tick();
        tick();
        @(posedge clk);
        #2;
        rst = 1;
        m_ready = 0;
        d_req = 1; d_addr = 32'h500; d_we = 0;
        samp();
        check("rst_first_gnt", d_gnt, 1);
        check("rst_no_valid", d_valid, 0);
        tick();
        d_req = 0; m_ready = 1; m_rdata = 32'h600DF00D;
        samp();
        check("rst_no_valid2", d_valid, 0);
        tick();
        m_ready = 0;
        samp();
        check("rst_new_valid", d_rdata, 32'h600DF00D);

        // fairness under continuous demand
        tick();
        d_req = 1; d_addr = 32'h600; d_we = 0;
        i_req = 1; i_addr = 32'h700;
        m_ready = 1; m_rdata = 32'h0F0F0F0F;
        for (int k = 0; k < 10; k++) begin
            samp();
            got = d_gnt ? "D" : (i_gnt ? "I" : "-");
            check($sformatf("fair_grant%0d", k), got, exp_pat[k]);
            tick();
        end
        d_req = 0; i_req = 0;
        tick();
        m_ready = 0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have these parameters: AW 32 address width; DW 32 data width; MAX_DSTREAK 4 consecutive data grants allowed while fetch waits (used only under MEM_ARB_FAIR_EN).
REQ-002 The block SHALL have one clock, and reset SHALL be asynchronous and active-low.
REQ-003 The ports SHALL be:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- i_req  in  1  fetch request
- i_addr  in  AW  fetch address
- i_flush  in  1  discard outstanding fetch (taken branch)
- i_gnt  out  1  fetch accepted
- i_valid  out  1  fetch data valid pulse
- i_rdata  out  DW  fetch data
- d_req  in  1  load/store request
- d_addr  in  AW  data address
- d_we  in  4  byte write enables; 0 means load
- d_wdata  in  DW  store data
- d_gnt  out  1  data accepted
- d_valid  out  1  load data or store acknowledge pulse
- d_rdata  out  DW  load data
- m_req  out  1  memory access active
- m_addr  out  AW  memory address
- m_we  out  4  memory byte enables
- m_wdata  out  DW  memory write data
- m_ready  in  1  memory completes the access this cycle
- m_rdata  in  DW  memory read data

Function
REQ-004 The block SHALL implement the FSM states IDLE, IBUSY and DBUSY.
REQ-005 Arbitration SHALL happen in IDLE, or in a BUSY state in the cycle m_ready=1. The requester chosen SHALL see a combinational one-cycle gnt pulse, and the FSM SHALL enter DBUSY or IBUSY at the next edge.
REQ-006 Requesters SHALL hold req, addr, we and wdata stable until gnt. On gnt the block SHALL latch addr, we and wdata into m_addr, m_we and m_wdata, which SHALL be registered.
REQ-007 m_req SHALL be high exactly while in IBUSY or DBUSY. For IBUSY, m_we SHALL be 0.
REQ-008 When m_ready=1 in DBUSY, the block SHALL register d_valid=1 and d_rdata=m_rdata for one cycle. For stores, d_rdata SHALL be 0.
REQ-009 When m_ready=1 in IBUSY, the block SHALL register i_valid=1 and i_rdata=m_rdata for one cycle, unless the fetch was flushed.
REQ-010 Minimum latency: a request at cycle t with m_ready=1 at t+1 SHALL give valid at t+2. Back-to-back accesses SHALL issue with no idle cycle.
REQ-011 Default priority: d_req SHALL win over i_req when both are high in the arbitration cycle.
REQ-012 Flush:
- i_flush in IBUSY SHALL set a flushed flag. The memory access SHALL still complete, but i_valid SHALL be suppressed.
- i_flush in the same cycle as m_ready SHALL also suppress i_valid.
- i_flush in IDLE or DBUSY SHALL have no effect.
- The flag SHALL clear on leaving IBUSY.
REQ-013 If no requester is pending at completion, the FSM SHALL return to IDLE with m_req=0.
REQ-014 The block SHALL never assert i_gnt and d_gnt in the same cycle.

Reset
REQ-015 rst=0 SHALL asynchronously force:
- state IDLE;
- m_req, m_we, i_valid, d_valid, flushed flag and streak counter all 0;
- m_addr, m_wdata, i_rdata and d_rdata all 0.
REQ-016 An access in flight at reset SHALL be abandoned with no valid issued. The first grant SHALL be possible in the first cycle after rst deasserts.

Configuration
REQ-017 With MEM_ARB_FAIR_EN defined, a streak counter SHALL count data grants made while i_req=1. It SHALL reset to 0 on any fetch grant or when i_req=0.
- When the counter equals MAX_DSTREAK, the next arbitration SHALL grant fetch if i_req=1.
REQ-018 Without MEM_ARB_FAIR_EN, the block SHALL use strict data priority with no counter logic.

Structure
REQ-019 Package mem_arb_pkg SHALL hold the FSM state enum and the MAX_DSTREAK default constant.
REQ-020 The streak counter SHALL be the sub-module mem_arb_streak, instantiated only under MEM_ARB_FAIR_EN.

Verification
REQ-021 Single load scenario:
- Stimulus: d_req=1, d_addr=0x100, d_we=0 at t; m_ready=1 at t+1 with m_rdata=0xDEADBEEF.
- Required response: d_gnt at t; m_req and m_addr=0x100 at t+1; d_valid with d_rdata=0xDEADBEEF at t+2.
REQ-022 Collision scenario:
- Stimulus: i_req (0x40) and d_req (store 0x200, d_we=0xF, d_wdata=0x12345678) both high at t.
- Required response: d_gnt at t, with m_we=0xF and m_wdata=0x12345678. i_gnt in the m_ready cycle; the fetch issues next with no idle cycle.
REQ-023 Flush scenario:
- Stimulus: fetch 0x80 granted; i_flush=1 one cycle later; m_ready=1 two cycles later.
- Required response: no i_valid; FSM returns to IDLE.
REQ-024 Wait-state scenario:
- Stimulus: m_ready held 0 for 5 cycles during a load.
- Required response: m_req, m_addr and m_we stable throughout; exactly one d_valid after m_ready.
REQ-025 Reset scenario:
- Stimulus: rst=0 asynchronously mid-DBUSY.
- Required response: m_req=0 immediately, and no d_valid after release.
REQ-026 Fairness scenario (MEM_ARB_FAIR_EN, MAX_DSTREAK=4):
- Stimulus: continuous d_req and i_req.
- Required response: grant pattern D,D,D,D,I repeating. Without the macro, only D grants occur.
